// File: rtl/merlin_lsu_pkg.sv
// Shared memory-op encodings and lane helpers for the merlin load/store unit.
// Store funct3 values reuse the LB/LH/LW encodings.
package merlin_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  function automatic logic memop_legal(input logic store, input logic [2:0] f3);
    case (f3)
      MEMOP_LB, MEMOP_LH, MEMOP_LW: return 1'b1;
      MEMOP_LBU, MEMOP_LHU:         return ~store;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic memop_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'hF;
    endcase
  endfunction

  // Replicating the data lets the byte enables alone pick the target lane.
  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] wdata);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/merlin_lsu_align.sv
// Load-side lane extraction: picks the byte/halfword at the captured offset
// and sign- or zero-extends it according to funct3.
module merlin_lsu_align
  import merlin_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sext     = ~funct3_i[2];
    case (funct3_i[1:0])
      2'b00:   result_o = {{24{sext & byte_sel[7]}}, byte_sel};
      2'b01:   result_o = {{16{sext & half_sel[15]}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/merlin_lsu.sv
// Load/store unit: one bus transaction per memory op, stalling until the
// response returns; misaligned or illegal ops are flagged without bus traffic.
module merlin_lsu
  import merlin_lsu_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            lsu_valid_i,
  input  logic            lsu_store_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_stall_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_rdata_valid_o,
  output logic            lsu_misalign_o,
  output logic            lsu_fault_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_err_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic            op_legal, op_aligned, op_accept, resp_done, load_ok;
  logic            req_q, we_q, rdata_valid_q, misalign_q, fault_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, load_result;
  logic [3:0]      be_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;

  assign op_legal   = memop_legal(lsu_store_i, lsu_funct3_i);
  assign op_aligned = memop_aligned(lsu_funct3_i, lsu_addr_i[1:0]);
  assign op_accept  = (state_q == ST_IDLE) & lsu_valid_i & op_legal & op_aligned;
  assign resp_done  = (state_q == ST_RESP) & dbus_rvalid_i;
  assign load_ok    = resp_done & ~we_q & ~dbus_err_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_accept)     state_d = ST_REQ;
      ST_REQ:  if (dbus_gnt_i)    state_d = ST_RESP;
      ST_RESP: if (dbus_rvalid_i) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lsu_stall_o = op_accept | (state_q == ST_REQ) | ((state_q == ST_RESP) & ~dbus_rvalid_i);
  end

  merlin_lsu_align u_align (
    .rdata_i  (dbus_rdata_i),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .result_o (load_result)
  );

  // Bus fields are captured once at acceptance so they stay stable until grant.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      req_q <= (state_d == ST_REQ);
      if (op_accept) begin
        we_q     <= lsu_store_i;
        addr_q   <= {lsu_addr_i[XLEN-1:2], 2'b00};
        be_q     <= lane_be(lsu_funct3_i, lsu_addr_i[1:0]);
        wdata_q  <= lane_wdata(lsu_funct3_i, lsu_wdata_i);
        funct3_q <= lsu_funct3_i;
        off_q    <= lsu_addr_i[1:0];
      end
      if (load_ok) rdata_q <= load_result;
      rdata_valid_q <= load_ok;
      misalign_q    <= (state_q == ST_IDLE) & lsu_valid_i & op_legal & ~op_aligned;
      fault_q       <= ((state_q == ST_IDLE) & lsu_valid_i & ~op_legal)
                     | (resp_done & dbus_err_i);
    end
  end

  assign dbus_req_o        = req_q;
  assign dbus_we_o         = we_q;
  assign dbus_addr_o       = addr_q;
  assign dbus_be_o         = be_q;
  assign dbus_wdata_o      = wdata_q;
  assign lsu_rdata_o       = rdata_q;
  assign lsu_rdata_valid_o = rdata_valid_q;
  assign lsu_misalign_o    = misalign_q;
  assign lsu_fault_o       = fault_q;

endmodule

// File: doc/merlin_lsu.md
# merlin_lsu

Load/store unit sitting directly downstream of the ALU in the execute/memory boundary. It takes the ALU's registered result as the effective address, issues one data-bus transaction per memory instruction, and stalls the pipeline until the response returns. It performs byte-lane steering for stores, alignment and sign/zero extension for loads, and flags misaligned or illegal accesses without touching the bus.

## Interface
- Parameters: none; data/address width is `` `RV_XLEN`` (32).
- clk_i  in  1  core clock
- reset_i  in  1  synchronous, active-low reset
- lsu_valid_i  in  1  memory op present; held stable by upstream while lsu_stall_o=1
- lsu_store_i  in  1  1=store, 0=load
- lsu_funct3_i  in  3  access size/sign (RISC-V funct3)
- lsu_addr_i  in  32  effective address (ALU result)
- lsu_wdata_i  in  32  store data (rs2)
- lsu_stall_o  out  1  hold upstream stages
- lsu_rdata_o  out  32  aligned/extended load result
- lsu_rdata_valid_o  out  1  one-cycle pulse, load result valid
- lsu_misalign_o  out  1  one-cycle pulse, misaligned access
- lsu_fault_o  out  1  one-cycle pulse, illegal funct3 or bus error
- dbus_req_o  out  1  request valid
- dbus_we_o  out  1  write enable
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-steered write data
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  response valid (loads and stores)
- dbus_rdata_i  in  32  read data
- dbus_err_i  in  1  response error, qualified by dbus_rvalid_i

## Operation
- States: IDLE, REQ, RESP.
- IDLE: on lsu_valid_i, decode funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU illegal for stores). Others -> fault.
  - Legal and aligned: capture we/addr/be/wdata/funct3/addr[1:0] into registers, -> REQ.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): no request; lsu_misalign_o pulses next cycle; stay IDLE.
  - Illegal funct3: no request; lsu_fault_o pulses next cycle; stay IDLE.
- REQ: dbus_req_o=1 with stable fields until dbus_gnt_i; on gnt -> RESP.
- RESP: wait dbus_rvalid_i; then -> IDLE. Load without error: lsu_rdata_o updated, lsu_rdata_valid_o pulses next cycle. dbus_err_i=1: lsu_fault_o pulses instead, lsu_rdata_valid_o stays 0. Store success: no output pulse.
- Store steering: B be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; H be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}; W be=4'hF.
- Load extraction: byte/halfword selected by captured addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passthrough. Loads drive be as stores do.
- lsu_stall_o (combinational) = (IDLE & lsu_valid_i & legal & aligned) | REQ | (RESP & ~dbus_rvalid_i). Misaligned/illegal ops do not stall.
- dbus_rvalid_i in IDLE or REQ is ignored.

## Timing
- Reset (reset_i=0 at edge): state IDLE; dbus_req_o, lsu_rdata_valid_o, lsu_misalign_o, lsu_fault_o = 0; lsu_rdata_o = 0; dbus_* data/addr/be registers = 0. Takes effect mid-transaction; request drops the cycle after; late responses ignored.
- Best case: valid at cycle N, req at N+1, gnt at N+1, rvalid at N+2, stall low in N+2, rdata_valid at N+3. Load latency 3 cycles; back-to-back ops accepted in the cycle after rvalid.
- Bus rule: rvalid no earlier than the cycle after gnt; one outstanding transaction.
- dbus_* outputs are registered; no combinational path from lsu_*_i to dbus_*.

## Structure
- Shared header riscv_defs.v: `` `RV_MEMOP_LB/LH/LW/LBU/LHU/SB/SH/SW`` funct3 constants.
- State encoding local to the module.
- One natural sub-module: merlin_lsu_align (combinational load extraction: rdata, addr[1:0], funct3 -> 32-bit result).

## Test plan
- LW addr 0x1000, gnt same cycle as req, rdata 0xDEADBEEF one cycle later -> dbus_addr 0x1000, be 4'hF, lsu_rdata_o 0xDEADBEEF with 1-cycle valid pulse at N+3.
- LB addr 0x1003, rdata 0x80123456 -> be 4'b1000, result 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x1002 -> 0xFFFF8012.
- SH addr 0x2002 wdata 0x0000ABCD, gnt delayed 3 cycles -> req/fields stable 4 cycles, be 4'b1100, wdata 0xABCDABCD, stall held until rvalid.
- LW addr 0x1001 -> no dbus_req_o, lsu_misalign_o 1-cycle pulse, no stall; funct3 3'b011 -> lsu_fault_o pulse.
- Load with dbus_err_i=1 on rvalid -> lsu_fault_o pulse, lsu_rdata_valid_o stays 0, returns IDLE.
- reset_i=0 while in RESP, then rvalid arrives -> IDLE, all pulse outputs 0, response ignored, next load completes normally.
